// File: rtl/drum_pitch_sweep.sv
// Pitch-envelope generator for the one-shot drum voices.
// On a rising trig it sweeps p_frequency from base up to peak one code at a time, then back
// down to base. Each step waits a programmable number of mclk cycles. While idle, the output
// follows the live base_freq input.
module drum_pitch_sweep #(
    parameter int unsigned FREQ_RES_BITS = 8,
    parameter int unsigned STEP_DIV_BITS = 16
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     trig,
    input  logic [FREQ_RES_BITS-1:0] base_freq,
    input  logic [FREQ_RES_BITS-1:0] peak_freq,
    input  logic [STEP_DIV_BITS-1:0] rise_div,
    input  logic [STEP_DIV_BITS-1:0] fall_div,
    output logic [FREQ_RES_BITS-1:0] p_frequency,
    output logic                     active,
    output logic                     done
);

    typedef enum logic [1:0] {
        StIdle,
        StRise,
        StFall
    } state_t;

    state_t                   state;
    logic                     trig_q;
    logic [STEP_DIV_BITS-1:0] cnt;

    // Sweep parameters captured at the trigger, so the knobs can move mid-sweep safely
    logic [FREQ_RES_BITS-1:0] base_q;
    logic [FREQ_RES_BITS-1:0] peak_q;
    logic [STEP_DIV_BITS-1:0] rise_div_q;
    logic [STEP_DIV_BITS-1:0] fall_div_q;

    logic trig_rise;

    // Edge detect on the level trigger; a held trig yields one sweep only
    always_comb begin
        trig_rise = trig & ~trig_q;
    end

    // Sweep FSM with registered outputs; a new trigger preempts every state, including the
    // completion cycle, so a retrigger never emits a done pulse
    always_ff @(posedge mclk) begin
        if (rst) begin
            state       <= StIdle;
            trig_q      <= 1'b0;
            cnt         <= '0;
            base_q      <= '0;
            peak_q      <= '0;
            rise_div_q  <= '0;
            fall_div_q  <= '0;
            p_frequency <= '0;
            active      <= 1'b0;
            done        <= 1'b0;
        end else begin
            trig_q <= trig;
            done   <= 1'b0;
            if (trig_rise) begin
                base_q      <= base_freq;
                peak_q      <= peak_freq;
                rise_div_q  <= rise_div;
                fall_div_q  <= fall_div;
                p_frequency <= base_freq;
                cnt         <= '0;
                state       <= StRise;
                active      <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        p_frequency <= base_freq;
                        active      <= 1'b0;
                    end
                    StRise: begin
                        // Compare with >= so peak <= base drops straight into FALL
                        if (p_frequency >= peak_q) begin
                            state <= StFall;
                            cnt   <= '0;
                        end else if (cnt == rise_div_q) begin
                            p_frequency <= p_frequency + FREQ_RES_BITS'(1);
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + STEP_DIV_BITS'(1);
                        end
                    end
                    StFall: begin
                        if (p_frequency <= base_q) begin
                            state  <= StIdle;
                            active <= 1'b0;
                            done   <= 1'b1;
                        end else if (cnt == fall_div_q) begin
                            p_frequency <= p_frequency - FREQ_RES_BITS'(1);
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + STEP_DIV_BITS'(1);
                        end
                    end
                    default: begin
                        state  <= StIdle;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drum_pitch_sweep.sv
// Scoreboard bench for drum_pitch_sweep. The reference model describes a sweep by its elapsed
// time since the trigger, using closed-form arithmetic. It pushes one expected output per clock.
// A separate negedge monitor pops those expectations and compares them with the DUT outputs.
module tb_drum_pitch_sweep;

    localparam int unsigned FRB = 8;
    localparam int unsigned SDB = 16;

    logic           mclk;
    logic           rst;
    logic           trig;
    logic [FRB-1:0] base_freq;
    logic [FRB-1:0] peak_freq;
    logic [SDB-1:0] rise_div;
    logic [SDB-1:0] fall_div;
    logic [FRB-1:0] p_frequency;
    logic           active;
    logic           done;

    drum_pitch_sweep #(
        .FREQ_RES_BITS(FRB),
        .STEP_DIV_BITS(SDB)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .trig       (trig),
        .base_freq  (base_freq),
        .peak_freq  (peak_freq),
        .rise_div   (rise_div),
        .fall_div   (fall_div),
        .p_frequency(p_frequency),
        .active     (active),
        .done       (done)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct packed {
        logic [FRB-1:0] freq;
        logic           active;
        logic           done;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    done_seen   = 0;
    int    cycle       = 0;
    string phase       = "reset";

    // Reference model: a sweep is a function of time t since the trigger edge
    bit   m_busy = 1'b0;
    bit   m_trig_prev = 1'b0;
    int   m_t, m_n, m_rise_len, m_len;
    int   lb, lp, lrd, lfd;
    exp_t cur = '0;

    always @(posedge mclk) begin
        cycle++;
        if (rst) begin
            cur         = '0;
            m_trig_prev = 1'b0;
            m_busy      = 1'b0;
        end else begin
            cur.done = 1'b0;
            if (trig && !m_trig_prev) begin
                lb  = int'(base_freq);
                lp  = (peak_freq > base_freq) ? int'(peak_freq) : int'(base_freq);
                lrd = int'(rise_div);
                lfd = int'(fall_div);
                m_t        = 0;
                m_busy     = 1'b1;
                cur.freq   = base_freq;
                cur.active = 1'b1;
            end else if (m_busy) begin
                m_t++;
                m_n        = lp - lb;
                m_rise_len = m_n * (lrd + 1);
                m_len      = m_rise_len + 1 + m_n * (lfd + 1) + 1;
                if (m_t == m_len) begin
                    m_busy     = 1'b0;
                    cur.active = 1'b0;
                    cur.done   = 1'b1;
                    cur.freq   = FRB'(lb);
                end else if (m_t <= m_rise_len) begin
                    cur.freq = FRB'(lb + m_t / (lrd + 1));
                end else begin
                    cur.freq = FRB'(lp - (m_t - m_rise_len - 1) / (lfd + 1));
                end
            end else begin
                cur.freq   = base_freq;
                cur.active = 1'b0;
            end
            m_trig_prev = trig;
        end
        exp_q.push_back(cur);
    end

    // Monitor: compare one expected output per clock, away from the active edge
    always @(negedge mclk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (done === 1'b1) done_seen++;
            if (p_frequency !== e.freq || active !== e.active || done !== e.done) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got freq=%0d active=%b done=%b, want freq=%0d active=%b done=%b",
                         phase, cycle, p_frequency, active, done, e.freq, e.active, e.done);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step(1);
        trig = 1'b0;
    endtask

    task automatic check_done(input string name, input int want);
        step(2);
        vectors++;
        if (done_seen != want) begin
            miscompares++;
            $display("FAIL %s done pulses: got %0d, want %0d", name, done_seen, want);
        end
    endtask

    task automatic set_basic();
        base_freq = 8'd48;
        peak_freq = 8'd52;
        rise_div  = 16'd1;
        fall_div  = 16'd3;
    endtask

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        set_basic();
        step(4);
        rst = 1'b0;
        step(3);

        phase = "basic";
        done_seen = 0;
        pulse_trig();
        step(30);
        check_done("basic", 1);

        phase = "held";
        done_seen = 0;
        trig = 1'b1;
        step(100);
        trig = 1'b0;
        step(3);
        check_done("held", 1);

        phase = "retrig";
        done_seen = 0;
        pulse_trig();
        step(17);
        pulse_trig();
        step(5);
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL retrig early done: got %0d, want 0", done_seen);
        end
        step(30);
        check_done("retrig", 1);

        phase = "degenerate";
        done_seen = 0;
        peak_freq = 8'd40;
        pulse_trig();
        step(6);
        check_done("degenerate", 1);

        phase = "latching";
        set_basic();
        done_seen = 0;
        pulse_trig();
        step(5);
        base_freq = 8'd20;
        peak_freq = 8'd200;
        rise_div  = 16'd0;
        step(30);
        check_done("latching", 1);

        phase = "midreset";
        set_basic();
        step(2);
        done_seen = 0;
        pulse_trig();
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);
        check_done("midreset", 0);

        phase = "fullrange";
        base_freq = 8'd0;
        peak_freq = 8'd255;
        rise_div  = 16'd0;
        fall_div  = 16'd0;
        done_seen = 0;
        pulse_trig();
        step(520);
        check_done("fullrange", 1);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                base_freq = 8'($urandom_range(0, 255));
                peak_freq = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'(base_freq + $urandom_range(0, 12));
                rise_div  = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 65535))
                                                          : 16'($urandom_range(0, 3));
                fall_div  = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 24) == 0) trig = ~trig;
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst  = 1'b0;
        trig = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
